// File: rtl/axi_wr_arbiter_pkg.sv
// Shared types for the AXI write arbiter: FSM state and AXI burst-type encodings.
package axi_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam logic [1:0] FIXED = 2'd0;
  localparam logic [1:0] INCR  = 2'd1;
  localparam logic [1:0] WRAP  = 2'd2;

endpackage

// File: rtl/axi_wr_arbiter_if.sv
// AXI write address + write data channels for N ports, flattened per field (port i at slice i).
interface axi_wr_arbiter_if #(
  parameter int N          = 1,
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [N*ID_WIDTH-1:0]   awid;
  logic [N*ADDR_WIDTH-1:0] awaddr;
  logic [N*8-1:0]          awlen;
  logic [N*3-1:0]          awsize;
  logic [N*2-1:0]          awburst;
  logic [N-1:0]            awvalid;
  logic [N-1:0]            awready;
  logic [N*DATA_WIDTH-1:0] wdata;
  logic [N*STRB_WIDTH-1:0] wstrb;
  logic [N-1:0]            wlast;
  logic [N-1:0]            wvalid;
  logic [N-1:0]            wready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready
  );
endinterface

// File: rtl/axi_wr_arbiter_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module arb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  localparam logic [IW:0] NUM = (IW+1)'(N);

  always_comb begin : pick
    logic [IW:0] j;
    grant = '0;
    idx   = '0;
    j     = '0;
    // Walk the search order backwards so the last hit is the earliest from ptr.
    for (int k = N - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + (IW+1)'(k);
      if (j >= NUM) j = j - NUM;
      if (req[j[IW-1:0]]) idx = j[IW-1:0];
    end
    any = |req;
    grant[idx] = any;
  end
endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin AW arbiter locking the grant until both AW and the WLAST beat complete; AW 1-cycle, W 0-cycle.
// Define AXI_WR_ARB_ID_PREFIX_EN to prefix m_axi awid with the granted port index.
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int S_COUNT    = 4,
  parameter int S_ID_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic             clk,
  input  logic             rstn,
  axi_wr_arbiter_if.slave  s_axi,
  axi_wr_arbiter_if.master m_axi
);
  localparam int IW = $clog2(S_COUNT);
`ifdef AXI_WR_ARB_ID_PREFIX_EN
  localparam int M_ID_WIDTH = S_ID_WIDTH + IW;
`else
  localparam int M_ID_WIDTH = S_ID_WIDTH;
`endif

  arb_state_t            state;
  logic [IW-1:0]         g, ptr, next_ptr, pick_idx;
  logic [S_COUNT-1:0]    pick_grant;
  logic                  pick_any;
  logic                  aw_done, w_done;
  logic [S_ID_WIDTH-1:0] awid_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]            awlen_q;
  logic [2:0]            awsize_q;
  logic [1:0]            awburst_q;
  logic [M_ID_WIDTH-1:0] m_id;
  logic                  fwd, aw_fire, wlast_fire, aw_done_nxt, w_done_nxt;

  arb_rr_pick #(.N(S_COUNT)) u_pick (
    .req   (s_axi.awvalid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef AXI_WR_ARB_ID_PREFIX_EN
  assign m_id = {g, awid_q};
`else
  assign m_id = awid_q;
`endif

  assign s_axi.awready = (state == IDLE) ? pick_grant : '0;

  assign m_axi.awvalid = (state == BUSY) && !aw_done;
  assign m_axi.awid    = m_id;
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awlen   = awlen_q;
  assign m_axi.awsize  = awsize_q;
  assign m_axi.awburst = awburst_q;

  // W is a pure pass-through of the granted port until its WLAST beat is accepted.
  assign fwd           = (state == BUSY) && !w_done;
  assign m_axi.wvalid  = fwd & s_axi.wvalid[g];
  assign m_axi.wlast   = fwd & s_axi.wlast[g];
  assign m_axi.wdata   = fwd ? s_axi.wdata[g*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign m_axi.wstrb   = fwd ? s_axi.wstrb[g*STRB_WIDTH +: STRB_WIDTH] : '0;
  assign s_axi.wready  = fwd ? ({{(S_COUNT-1){1'b0}}, m_axi.wready[0]} << g) : '0;

  assign aw_fire     = m_axi.awvalid[0] & m_axi.awready[0];
  assign wlast_fire  = m_axi.wvalid[0] & m_axi.wready[0] & m_axi.wlast[0];
  assign aw_done_nxt = aw_done | aw_fire;
  assign w_done_nxt  = w_done | wlast_fire;
  assign next_ptr    = (g == IW'(S_COUNT - 1)) ? '0 : g + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      g         <= '0;
      ptr       <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      awid_q    <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      awburst_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state     <= BUSY;
            g         <= pick_idx;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            awid_q    <= s_axi.awid[pick_idx*S_ID_WIDTH +: S_ID_WIDTH];
            awaddr_q  <= s_axi.awaddr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            awlen_q   <= s_axi.awlen[pick_idx*8 +: 8];
            awsize_q  <= s_axi.awsize[pick_idx*3 +: 3];
            awburst_q <= s_axi.awburst[pick_idx*2 +: 2];
          end
        end
        BUSY: begin
          aw_done <= aw_done_nxt;
          w_done  <= w_done_nxt;
          if (aw_done_nxt && w_done_nxt) begin
            state <= IDLE;
            ptr   <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: per-port burst sources, a transaction-level arbitration model, directed scenarios.
module tb_axi_wr_arbiter;
  import axi_arb_pkg::*;

  localparam int S   = 4;
  localparam int IDW = 8;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;
`ifdef AXI_WR_ARB_ID_PREFIX_EN
  localparam int MIDW = IDW + 2;
  localparam logic [MIDW-1:0] EXP_T6_ID = 10'h35A;
`else
  localparam int MIDW = IDW;
  localparam logic [MIDW-1:0] EXP_T6_ID = 8'h5A;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  axi_wr_arbiter_if #(.N(S), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) s_if ();
  axi_wr_arbiter_if #(.N(1), .ID_WIDTH(MIDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) m_if ();

  axi_wr_arbiter #(
    .S_COUNT(S), .S_ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .s_axi (s_if),
    .m_axi (m_if)
  );

  // Upstream sources: each port issues awtotal bursts of blen beats; W may run ahead of AW.
  int          awtotal[S], awcnt[S], wtotal[S], wcnt[S], blen[S];
  logic [7:0]  idp[S];
  logic [31:0] basep[S];
  logic        m_awready, m_wready;
  int          tc, aw_hold;

  assign m_if.awready = m_awready;
  assign m_if.wready  = m_wready;

  always_comb begin
    for (int i = 0; i < S; i++) begin
      s_if.awvalid[i]           = awcnt[i] < awtotal[i];
      s_if.awid[i*IDW +: IDW]   = idp[i];
      s_if.awaddr[i*AW +: AW]   = basep[i] + 32'(awcnt[i]) * 32'h100;
      s_if.awlen[i*8 +: 8]      = 8'(blen[i] - 1);
      s_if.awsize[i*3 +: 3]     = 3'd2;
      s_if.awburst[i*2 +: 2]    = INCR;
      s_if.wvalid[i]            = wcnt[i] < wtotal[i];
      s_if.wdata[i*DW +: DW]    = {8'(i), 8'hA5, 16'(wcnt[i])};
      s_if.wstrb[i*SW +: SW]    = 4'(i + 1);
      s_if.wlast[i]             = ((wcnt[i] + 1) % blen[i]) == 0;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state and per-test observations (written only by the compare process).
  int               o = -1;
  int               mptr = 0;
  bit               owed, open;
  logic [IDW-1:0]   c_id;
  logic [31:0]      c_addr;
  logic [7:0]       c_len;
  logic [2:0]       c_size;
  logic [1:0]       c_burst;
  int               glog[$];
  int               gcyc[$];
  int               cyc, n_awv, n_wb, last_wl, w0_seen, n_p2, first_awv;
  logic [MIDW-1:0]  obs_awid;
  int               test_id = 0;
  int               seen_test = -1;
  bit               chk_en = 1'b0;

  logic [S-1:0]     e_awr, e_wr;
  logic [MIDW-1:0]  e_id;
  int               sel;
  bit               e_awv, e_fwd, e_wv;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (test_id != seen_test) begin
          seen_test = test_id;
          glog.delete(); gcyc.delete();
          cyc = 0; n_awv = 0; n_wb = 0; last_wl = 0; w0_seen = 0; n_p2 = 0; first_awv = -1;
          obs_awid = '0;
        end
        if (!rstn) begin
          check("rst_awready", 64'(s_if.awready), 0);
          check("rst_wready", 64'(s_if.wready), 0);
          check("rst_m_awvalid", 64'(m_if.awvalid), 0);
          check("rst_m_wvalid", 64'(m_if.wvalid), 0);
          check("rst_aw_fields", {m_if.awid, m_if.awaddr, m_if.awlen, m_if.awsize, m_if.awburst}, 0);
          o = -1; mptr = 0; owed = 1'b0; open = 1'b0;
        end else begin
          // Arbitration: first requester at or after the pointer, only when nobody owns the port.
          e_awr = '0;
          sel = -1;
          if (o < 0)
            for (int k = 0; k < S; k++)
              if (sel < 0 && s_if.awvalid[(mptr + k) % S]) sel = (mptr + k) % S;
          if (sel >= 0) e_awr[sel] = 1'b1;
          check("awready", 64'(s_if.awready), 64'(e_awr));

          e_awv = (o >= 0) && owed;
          check("m_awvalid", 64'(m_if.awvalid), 64'(e_awv));
`ifdef AXI_WR_ARB_ID_PREFIX_EN
          e_id = {2'(o), c_id};
`else
          e_id = c_id;
`endif
          if (e_awv && m_if.awvalid[0])
            check("aw_fields", {m_if.awid, m_if.awaddr, m_if.awlen, m_if.awsize, m_if.awburst},
                  {e_id, c_addr, c_len, c_size, c_burst});

          e_fwd = (o >= 0) && open;
          e_wv  = e_fwd && s_if.wvalid[o];
          e_wr  = '0;
          if (e_fwd) e_wr[o] = m_wready;
          check("m_wvalid", 64'(m_if.wvalid), 64'(e_wv));
          check("s_wready", 64'(s_if.wready), 64'(e_wr));
          if (e_wv && m_if.wvalid[0])
            check("w_beat", {m_if.wdata, m_if.wstrb, m_if.wlast},
                  {s_if.wdata[o*DW +: DW], s_if.wstrb[o*SW +: SW], s_if.wlast[o]});

          if (s_if.awready != '0) gcyc.push_back(cyc);
          if (m_if.awvalid[0]) begin
            n_awv++;
            if (first_awv < 0) begin first_awv = cyc; obs_awid = m_if.awid; end
          end
          if (m_if.wvalid[0] && m_wready) begin
            n_wb++;
            if (m_if.wlast[0]) last_wl = n_wb;
            if (m_if.wdata[31:24] == 8'd2) n_p2++;
          end
          if (s_if.wready[0]) w0_seen++;

          // Advance the model on this cycle's handshakes.
          if (o < 0 && sel >= 0) begin
            o = sel; owed = 1'b1; open = 1'b1;
            c_id    = s_if.awid[sel*IDW +: IDW];
            c_addr  = s_if.awaddr[sel*AW +: AW];
            c_len   = s_if.awlen[sel*8 +: 8];
            c_size  = s_if.awsize[sel*3 +: 3];
            c_burst = s_if.awburst[sel*2 +: 2];
            glog.push_back(sel);
          end else if (o >= 0) begin
            if (owed && m_awready) owed = 1'b0;
            if (open && s_if.wvalid[o] && m_wready && s_if.wlast[o]) open = 1'b0;
            if (!owed && !open) begin
              mptr = (o + 1) % S;
              o = -1;
            end
          end
          cyc++;
        end
      end
    end
  end

  task automatic clear_src();
    for (int i = 0; i < S; i++) begin
      awtotal[i] = 0; awcnt[i] = 0; wtotal[i] = 0; wcnt[i] = 0; blen[i] = 1;
      idp[i] = 8'(i); basep[i] = '0;
    end
  endtask

  task automatic set_port(input int p, input int nb, input int len, input logic [31:0] base, input logic [7:0] id);
    awtotal[p] = nb; awcnt[p] = 0; wtotal[p] = nb * len; wcnt[p] = 0;
    blen[p] = len; basep[p] = base; idp[p] = id;
  endtask

  task automatic cycle();
    logic [S-1:0] awh, wh;
    @(negedge clk);
    awh = s_if.awvalid & s_if.awready;
    wh  = s_if.wvalid & s_if.wready;
    @(posedge clk);
    #1;
    for (int i = 0; i < S; i++) begin
      if (awh[i]) awcnt[i]++;
      if (wh[i]) wcnt[i]++;
    end
    tc++;
    m_awready = (tc >= aw_hold);
  endtask

  task automatic run(input logic [S-1:0] mask, input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      cycle();
      done = (o < 0);
      for (int i = 0; i < S; i++)
        if (mask[i] && (awcnt[i] < awtotal[i] || wcnt[i] < wtotal[i])) done = 1'b0;
    end
    check("run_done", 64'(done), 1);
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    clear_src();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  function automatic int gl(input int i);
    return (i < glog.size()) ? glog[i] : -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[5];
    rstn = 1'b0; m_awready = 1'b1; m_wready = 1'b1; aw_hold = 0; tc = 0;
    clear_src();
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); #1 rstn = 1'b1;

    // Single port 1, 4-beat burst at 0x1000.
    test_id++;
    set_port(1, 1, 4, 32'h1000, 8'h11);
    run(4'b0010, 50);
    check("t1_ngrants", 64'(glog.size()), 1);
    check("t1_grant", 64'(gl(0)), 1);
    check("t1_awready_cyc", 64'(gcyc.size() > 0 ? gcyc[0] : -1), 0);
    check("t1_awvalid_cyc", 64'(first_awv), 1);
    check("t1_beats", 64'(n_wb), 4);
    check("t1_wlast_beat", 64'(last_wl), 4);
    check("t1_model_ptr", 64'(mptr), 2);

    // Pointer now at 2: ports 0 and 2 together must be served 2 then 0.
    test_id++;
    set_port(0, 1, 1, 32'h2000, 8'h20);
    set_port(2, 1, 1, 32'h3000, 8'h22);
    run(4'b0101, 50);
    check("t1b_first", 64'(gl(0)), 2);
    check("t1b_second", 64'(gl(1)), 0);

    // All ports continuously requesting single-beat bursts.
    reset_dut();
    test_id++;
    for (int i = 0; i < S; i++) set_port(i, 2, 1, 32'h4000 + 32'(i) * 32'h1000, 8'(8'h30 + i));
    run(4'b1111, 100);
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) check($sformatf("t2_order%0d", i), 64'(gl(i)), 64'(exp_order[i]));
    for (int i = 1; i < 5; i++)
      check($sformatf("t2_occupancy%0d", i), 64'(i < gcyc.size() ? gcyc[i] - gcyc[i-1] : -1), 2);
    check("t2_beats", 64'(n_wb), 8);

    // Downstream AW stalled for 5 busy cycles while W flows.
    reset_dut();
    test_id++;
    tc = 0; aw_hold = 6; m_awready = 1'b0;
    set_port(1, 1, 4, 32'h5000, 8'h41);
    run(4'b0010, 50);
    check("t3_awvalid_cycles", 64'(n_awv), 6);
    check("t3_beats", 64'(n_wb), 4);
    check("t3_wlast_beat", 64'(last_wl), 4);
    aw_hold = 0; m_awready = 1'b1;

    // Port 2 granted while port 0 pushes W with no AW.
    reset_dut();
    test_id++;
    set_port(2, 1, 3, 32'h6000, 8'h62);
    wtotal[0] = 2; blen[0] = 2;
    run(4'b0100, 50);
    check("t4_port0_wready", 64'(w0_seen), 0);
    check("t4_port2_beats", 64'(n_p2), 3);
    check("t4_port0_stalled", 64'(wcnt[0]), 0);
    clear_src();

    // Reset during beat 3 of port 3's 4-beat burst.
    reset_dut();
    test_id++;
    set_port(2, 1, 1, 32'h7000, 8'h72);
    set_port(3, 1, 4, 32'h7100, 8'h73);
    for (int n = 0; n < 40 && wcnt[3] < 2; n++) cycle();
    check("t5_reached_beat2", 64'(wcnt[3]), 2);
    check("t5_pre_wvalid", 64'(m_if.wvalid), 1);
    rstn = 1'b0;
    #1;
    check("t5_rst_m_awvalid", 64'(m_if.awvalid), 0);
    check("t5_rst_m_wvalid", 64'(m_if.wvalid), 0);
    check("t5_rst_awready", 64'(s_if.awready), 0);
    check("t5_rst_wready", 64'(s_if.wready), 0);
    clear_src();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    test_id++;
    set_port(0, 1, 1, 32'h7200, 8'h80);
    set_port(3, 1, 1, 32'h7300, 8'h83);
    run(4'b1001, 50);
    check("t5_next_grant", 64'(gl(0)), 0);
    check("t5_then", 64'(gl(1)), 3);

    // ID forwarding from port 3.
    test_id++;
    set_port(3, 1, 1, 32'h8000, 8'h5A);
    run(4'b1000, 50);
    check("t6_awid", 64'(obs_awid), 64'(EXP_T6_ID));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
